glb_sram_cfg_arbiter: RTL and testbench

//  Shares the global-buffer SRAM config chain between two requesters: req0 = JTAG, req1 = processor.

---
 rtl/glb_sram_cfg_arbiter_pkg.sv | 16 +
 rtl/glb_sram_cfg_arbiter_rr_arb2.sv | 32 +++
 rtl/glb_sram_cfg_arbiter.sv | 162 ++++++++++++++++
 tb/tb_glb_sram_cfg_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/glb_sram_cfg_arbiter_pkg.sv
// Shared types and default widths for the global-buffer SRAM cfg arbiter.
// Provides the arbiter FSM state encoding and default parameter values.
package glb_sram_cfg_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD_ISSUE,
    RD_WAIT
  } sram_cfg_arb_state_e;

  localparam int GLB_CFG_ADDR_W  = 32;
  localparam int GLB_CFG_DATA_W  = 32;
  localparam int GLB_CFG_TIMEOUT = 64;

endpackage

// File: rtl/glb_sram_cfg_arbiter_rr_arb2.sv
// glb_rr_arb2: 2-way round-robin picker with a last_grant register.
// Ports: clk, reset, req[1:0], en (accept window), grant[1:0] (one-hot).
module glb_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);

  // 1 after reset so that requester 0 wins the first tie
  logic last_grant;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      unique case (1'b1)
        (req == 2'b11): grant = last_grant ? 2'b01 : 2'b10;
        default:        grant = req;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (|grant) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/glb_sram_cfg_arbiter.sv
// Arbitrates JTAG (req0) and processor (req1) onto the GLB SRAM cfg chain.
// Ports: reqN_* handshakes/returns, cfg_* chain strobes, timeout_err pulse.
module glb_sram_cfg_arbiter
  import glb_sram_cfg_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = GLB_CFG_ADDR_W,
  parameter int DATA_WIDTH     = GLB_CFG_DATA_W,
  parameter int TIMEOUT_CYCLES = GLB_CFG_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_wr_en,
  input  logic                  req0_rd_en,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wr_data,
  output logic                  req0_ready,
  output logic [DATA_WIDTH-1:0] req0_rd_data,
  output logic                  req0_rd_data_valid,
  input  logic                  req1_wr_en,
  input  logic                  req1_rd_en,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wr_data,
  output logic                  req1_ready,
  output logic [DATA_WIDTH-1:0] req1_rd_data,
  output logic                  req1_rd_data_valid,
  output logic                  cfg_wr_en,
  output logic [ADDR_WIDTH-1:0] cfg_wr_addr,
  output logic [DATA_WIDTH-1:0] cfg_wr_data,
  output logic                  cfg_rd_en,
  output logic [ADDR_WIDTH-1:0] cfg_rd_addr,
  input  logic [DATA_WIDTH-1:0] cfg_rd_data,
  input  logic                  cfg_rd_data_valid,
  output logic                  timeout_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(TIMEOUT_CYCLES - 1);

  sram_cfg_arb_state_e state, state_nxt;

  logic [1:0]            req;
  logic [1:0]            grant;
  logic                  arb_en;
  logic                  accept;
  logic                  wr_sel;
  logic                  owner;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [CW-1:0]         cnt;
  logic                  rd_done;
  logic                  rd_tout;
  logic [DATA_WIDTH-1:0] ret_data;

  assign req[0] = req0_wr_en | req0_rd_en;
  assign req[1] = req1_wr_en | req1_rd_en;

  // ready must stay low while reset is asserted
  assign arb_en = (state == IDLE) && !reset;

  glb_rr_arb2 u_rr (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .en    (arb_en),
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign accept     = |grant;

  // write has priority when both strobes come from one requester
  assign wr_sel = grant[1] ? req1_wr_en : req0_wr_en;

  assign cfg_wr_addr = addr_q;
  assign cfg_rd_addr = addr_q;
  assign cfg_wr_data = data_q;

  assign ret_data = rd_done ? cfg_rd_data : '0;

  always_comb begin
    state_nxt = state;
    cfg_wr_en = 1'b0;
    cfg_rd_en = 1'b0;
    rd_done   = 1'b0;
    rd_tout   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = wr_sel ? WR : RD_ISSUE;
        end
      end
      WR: begin
        cfg_wr_en = 1'b1;
        state_nxt = IDLE;
      end
      RD_ISSUE: begin
        cfg_rd_en = 1'b1;
        state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        if (cfg_rd_data_valid) begin
          rd_done   = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          rd_tout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner              <= 1'b0;
      addr_q             <= '0;
      data_q             <= '0;
      cnt                <= '0;
      req0_rd_data       <= '0;
      req1_rd_data       <= '0;
      req0_rd_data_valid <= 1'b0;
      req1_rd_data_valid <= 1'b0;
      timeout_err        <= 1'b0;
    end else begin
      req0_rd_data_valid <= 1'b0;
      req1_rd_data_valid <= 1'b0;
      timeout_err        <= rd_tout;
      if (accept) begin
        owner  <= grant[1];
        addr_q <= grant[1] ? req1_addr : req0_addr;
        data_q <= grant[1] ? req1_wr_data
                           : req0_wr_data;
      end
      if (state == RD_ISSUE) begin
        cnt <= '0;
      end else if (state == RD_WAIT && !rd_done
                   && !rd_tout) begin
        cnt <= cnt + 1'b1;
      end
      if (rd_done || rd_tout) begin
        if (owner) begin
          req1_rd_data       <= ret_data;
          req1_rd_data_valid <= 1'b1;
        end else begin
          req0_rd_data       <= ret_data;
          req0_rd_data_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_glb_sram_cfg_arbiter.sv
// Scoreboard bench for glb_sram_cfg_arbiter with a chain response stub.
// Directed cases followed by randomized rounds against a transaction model.
module tb_glb_sram_cfg_arbiter;

  localparam int TO = 8;
  localparam int K_ACC = 0;
  localparam int K_WR  = 1;
  localparam int K_RD  = 2;
  localparam int K_RSP = 3;

  typedef struct {
    int          k;
    int          who;
    logic [31:0] a;
    logic [31:0] d;
    logic        t;
  } ev_t;

  typedef struct {
    int          d;
    logic [31:0] v;
  } st_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        d_wr [2];
  logic        d_rd [2];
  logic [31:0] d_ad [2];
  logic [31:0] d_wd [2];
  logic        r0_rdy, r1_rdy, r0v, r1v, terr;
  logic        cwe, cre;
  logic [31:0] r0d, r1d, cwa, cwd, cra;
  logic        sv;
  logic [31:0] sd;

  ev_t exq [$];
  st_t stq [$];
  st_t pend [$];
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  bit  lg = 1'b1;

  bit          ra_act [2];
  bit          ra_w [2];
  bit          ra_r [2];
  logic [31:0] ra_a [2];
  logic [31:0] ra_wd [2];
  int          ra_dl [2];
  logic [31:0] ra_rd [2];

  always #5 clk = ~clk;

  glb_sram_cfg_arbiter #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .req0_wr_en         (d_wr[0]),
    .req0_rd_en         (d_rd[0]),
    .req0_addr          (d_ad[0]),
    .req0_wr_data       (d_wd[0]),
    .req0_ready         (r0_rdy),
    .req0_rd_data       (r0d),
    .req0_rd_data_valid (r0v),
    .req1_wr_en         (d_wr[1]),
    .req1_rd_en         (d_rd[1]),
    .req1_addr          (d_ad[1]),
    .req1_wr_data       (d_wd[1]),
    .req1_ready         (r1_rdy),
    .req1_rd_data       (r1d),
    .req1_rd_data_valid (r1v),
    .cfg_wr_en          (cwe),
    .cfg_wr_addr        (cwa),
    .cfg_wr_data        (cwd),
    .cfg_rd_en          (cre),
    .cfg_rd_addr        (cra),
    .cfg_rd_data        (sd),
    .cfg_rd_data_valid  (sv),
    .timeout_err        (terr)
  );

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic pop_cmp(string nm, int k, int who,
                         logic [31:0] a, logic [31:0] d,
                         logic t);
    ev_t e;
    checks++;
    if (exq.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event k=%0d who=%0d",
               nm, k, who);
      return;
    end
    e = exq.pop_front();
    if (e.k != k || e.who != who || e.a !== a ||
        e.d !== d || e.t !== t) begin
      errors++;
      $display({"FAIL %s: got k=%0d who=%0d a=%h d=%h t=%b",
                " expected k=%0d who=%0d a=%h d=%h t=%b"},
               nm, k, who, a, d, t,
               e.k, e.who, e.a, e.d, e.t);
    end
  endtask

  // chain stub: replays scheduled read returns on their due cycle
  initial begin
    st_t tmp;
    sv = 1'b0;
    sd = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      sv = 1'b0;
      if (pend.size() != 0 && pend[0].d == cyc) begin
        tmp = pend.pop_front();
        sv = 1'b1;
        sd = tmp.v;
      end
    end
  end

  // monitor
  always @(negedge clk) begin
    st_t s;
    if (!reset) begin
      if (r0v) pop_cmp("rsp0", K_RSP, 0, 0, r0d, terr);
      if (r1v) pop_cmp("rsp1", K_RSP, 1, 0, r1d, terr);
      if (terr && !r0v && !r1v)
        chk("stray_timeout_err", terr, 0);
      if (r0_rdy && r1_rdy)
        chk("dual_ready", 1, 0);
      if (r0_rdy) pop_cmp("acc0", K_ACC, 0, 0, 0, 0);
      if (r1_rdy) pop_cmp("acc1", K_ACC, 1, 0, 0, 0);
      if (cwe) pop_cmp("cfg_wr", K_WR, 0, cwa, cwd, 0);
      if (cre) begin
        pop_cmp("cfg_rd", K_RD, 0, cra, 0, 0);
        if (stq.size() != 0) begin
          s = stq.pop_front();
          if (s.d > 0)
            pend.push_back('{cyc + s.d, s.v});
        end
      end
    end
  end

  task automatic clr_req();
    for (int i = 0; i < 2; i++) ra_act[i] = 1'b0;
  endtask

  task automatic set_req(int n, bit w, bit r,
                         logic [31:0] a, logic [31:0] wd,
                         int dl, logic [31:0] rd);
    ra_act[n] = 1'b1;
    ra_w[n]   = w;
    ra_r[n]   = r;
    ra_a[n]   = a;
    ra_wd[n]  = wd;
    ra_dl[n]  = dl;
    ra_rd[n]  = rd;
  endtask

  // transaction-level model: grant order, then chain and reply events
  task automatic model_round();
    int  ord [$];
    bit  ok;
    int  n;
    if (ra_act[0] && ra_act[1])
      ord = lg ? '{0, 1} : '{1, 0};
    else if (ra_act[0])
      ord = '{0};
    else
      ord = '{1};
    foreach (ord[i]) begin
      n = ord[i];
      exq.push_back('{K_ACC, n, 0, 0, 0});
      if (ra_w[n]) begin
        exq.push_back('{K_WR, 0, ra_a[n], ra_wd[n], 0});
      end else begin
        exq.push_back('{K_RD, 0, ra_a[n], 0, 0});
        stq.push_back('{ra_dl[n], ra_rd[n]});
        ok = ra_dl[n] >= 1 && ra_dl[n] <= TO;
        exq.push_back('{K_RSP, n, 0,
                        ok ? ra_rd[n] : 32'h0, !ok});
      end
      lg = n[0];
    end
  endtask

  task automatic drive(int n);
    int c = 0;
    d_wr[n] = ra_w[n];
    d_rd[n] = ra_r[n];
    d_ad[n] = ra_a[n];
    d_wd[n] = ra_wd[n];
    do begin
      @(negedge clk);
      c++;
    end while (!(n == 0 ? r0_rdy : r1_rdy) && c < 200);
    if (c >= 200) chk("ready_wait", 0, 1);
    @(posedge clk);
    #1;
    d_wr[n] = 1'b0;
    d_rd[n] = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    while ((exq.size() != 0 || stq.size() != 0 ||
            pend.size() != 0) && c < 300) begin
      @(posedge clk);
      c++;
    end
    repeat (2) @(posedge clk);
    chk("drain_queue", exq.size(), 0);
    #1;
  endtask

  task automatic run_round();
    model_round();
    fork
      begin if (ra_act[0]) drive(0); end
      begin if (ra_act[1]) drive(1); end
    join
    drain();
  endtask

  task automatic chk_idle(string tag);
    chk({tag, "_rdy0"}, r0_rdy, 0);
    chk({tag, "_rdy1"}, r1_rdy, 0);
    chk({tag, "_wr_en"}, cwe, 0);
    chk({tag, "_rd_en"}, cre, 0);
    chk({tag, "_v0"}, r0v, 0);
    chk({tag, "_v1"}, r1v, 0);
    chk({tag, "_terr"}, terr, 0);
    chk({tag, "_addr"}, cra, 0);
    chk({tag, "_data0"}, r0d, 0);
    chk({tag, "_data1"}, r1d, 0);
  endtask

  initial begin
    int m;
    int op;
    for (int i = 0; i < 2; i++) begin
      d_wr[i] = 1'b0;
      d_rd[i] = 1'b0;
      d_ad[i] = '0;
      d_wd[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk_idle("reset");
    @(posedge clk);
    #1;

    // simultaneous writes: req0 first, twice in a row
    for (int r = 0; r < 2; r++) begin
      clr_req();
      set_req(0, 1, 0, 32'h0000_1000 + r, 32'h1111_0000 + r,
              0, 0);
      set_req(1, 1, 0, 32'h0000_2000 + r, 32'h2222_0000 + r,
              0, 0);
      run_round();
    end

    clr_req();
    set_req(0, 1, 0, 32'h0001_0040, 32'hA5A5_0001, 0, 0);
    run_round();

    clr_req();
    set_req(1, 0, 1, 32'h0002_0008, 0, 5, 32'h1234_5678);
    run_round();

    // no response, late response, response on last cycle
    clr_req();
    set_req(0, 0, 1, 32'h0003_0010, 0, 0, 32'hDEAD_0001);
    run_round();
    clr_req();
    set_req(1, 0, 1, 32'h0003_0020, 0, 10, 32'hDEAD_0002);
    run_round();
    clr_req();
    set_req(0, 0, 1, 32'h0003_0030, 0, TO, 32'hCAFE_F00D);
    run_round();

    // write and read strobes together
    clr_req();
    set_req(1, 1, 1, 32'h0004_0000, 32'h0BAD_BEEF, 3,
            32'h5555_AAAA);
    run_round();

    // reset during RD_WAIT abandons the read
    clr_req();
    set_req(0, 0, 1, 32'h0005_0000, 0, 4, 32'h7777_7777);
    exq.push_back('{K_ACC, 0, 0, 0, 0});
    exq.push_back('{K_RD, 0, 32'h0005_0000, 0, 0});
    stq.push_back('{4, 32'h7777_7777});
    drive(0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    lg = 1'b1;
    @(negedge clk);
    chk_idle("mid_reset");
    drain();

    for (int r = 0; r < 60; r++) begin
      clr_req();
      m = $urandom_range(1, 3);
      for (int n = 0; n < 2; n++) begin
        if (m[n]) begin
          op = $urandom_range(0, 3);
          set_req(n, op == 0 || op == 2, op != 0,
                  $urandom, $urandom,
                  $urandom_range(0, 10), $urandom);
        end
      end
      run_round();
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
